// File: rtl/dds_sweep_sched_if.sv
// dds_sweep_sched_if: control/status bundle between the sweep scheduler,
// the rotary front end, the coefficient table and the oscillator.
interface dds_sweep_sched_if #(
    parameter int AW = 11,
    parameter int DW = 16
);
    logic          SweepEn;
    logic [AW-1:0] Rot_addr;
    logic          Rot_chng;
    logic [AW-1:0] Start_addr;
    logic [AW-1:0] Stop_addr;
    logic [AW-1:0] Step;
    logic [DW-1:0] Dwell;
    logic          Ready;
    logic [AW-1:0] address;
    logic          FreqChng;
    logic          Busy;
    logic          Wrap;

    modport master (
        output SweepEn, Rot_addr, Rot_chng,
        output Start_addr, Stop_addr, Step,
        output Dwell, Ready,
        input  address, FreqChng, Busy, Wrap
    );

    modport slave (
        input  SweepEn, Rot_addr, Rot_chng,
        input  Start_addr, Stop_addr, Step,
        input  Dwell, Ready,
        output address, FreqChng, Busy, Wrap
    );
endinterface

// File: rtl/dds_sweep_sched.sv
// dds_sweep_sched: owns the coefficient-table address and sequences
// table latency, FreqChng pulse and Ready handshake per change.
module dds_sweep_sched #(
    parameter int AW      = 11,
    parameter int DW      = 16,
    parameter int TBL_LAT = 1
) (
    input  logic              Fg_clk,
    input  logic              Reset,
    dds_sweep_sched_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE, SET, KICK, WAIT, DWELL
    } state_t;

    localparam logic [DW-1:0] SET_LD = DW'(TBL_LAT - 1);

    state_t        state;
    logic [AW-1:0] addr_q;
    logic          fchg_q;
    logic          busy_q;
    logic          wrap_q;
    logic [DW-1:0] cnt;
    logic          pend;

    logic [AW-1:0] inc;
    logic [AW:0]   nxt;
    logic          wrap_now;

    // Carry bit counts as "past the stop index" so the top of the
    // table never aliases back to a low address.
    always_comb begin
        inc      = (bus.Step == '0) ? AW'(1) : bus.Step;
        nxt      = {1'b0, addr_q} + {1'b0, inc};
        wrap_now = nxt[AW]
                || (nxt[AW-1:0] > bus.Stop_addr)
                || (bus.Start_addr >= bus.Stop_addr);
    end

    always_ff @(posedge Fg_clk or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            addr_q <= '0;
            fchg_q <= 1'b0;
            busy_q <= 1'b0;
            wrap_q <= 1'b0;
            cnt    <= '0;
            pend   <= 1'b0;
        end else begin
            fchg_q <= 1'b0;
            wrap_q <= 1'b0;
            if (bus.Rot_chng && !bus.SweepEn && state != IDLE)
                pend <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (bus.SweepEn) begin
                        addr_q <= bus.Start_addr;
                        cnt    <= SET_LD;
                        busy_q <= 1'b1;
                        state  <= SET;
                    end else if (bus.Rot_chng || pend) begin
                        addr_q <= bus.Rot_addr;
                        pend   <= 1'b0;
                        cnt    <= SET_LD;
                        busy_q <= 1'b1;
                        state  <= SET;
                    end
                end
                SET: begin
                    if (cnt == '0) begin
                        fchg_q <= 1'b1;
                        state  <= KICK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                KICK: begin
                    cnt   <= DW'(1);
                    state <= WAIT;
                end
                // cnt marks the first WAIT cycle, where Ready is ignored
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= '0;
                    end else if (bus.Ready) begin
                        if (bus.SweepEn) begin
                            cnt   <= bus.Dwell;
                            state <= DWELL;
                        end else begin
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                DWELL: begin
                    if (!bus.SweepEn) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else if (cnt <= DW'(1)) begin
                        if (wrap_now) begin
                            addr_q <= bus.Start_addr;
                            wrap_q <= 1'b1;
                        end else begin
                            addr_q <= nxt[AW-1:0];
                        end
                        cnt   <= SET_LD;
                        state <= SET;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.address  = addr_q;
    assign bus.FreqChng = fchg_q;
    assign bus.Busy     = busy_q;
    assign bus.Wrap     = wrap_q;
endmodule
